// File: rtl/test_pattern_gen_pkg.sv
// Shared definitions for the test pattern source: pattern codes, bar colours
// (packed as {g,r,b}) and small lookup helpers.
package test_pattern_gen_pkg;

   typedef enum logic [2:0] {
      TP_BARS    = 3'd0,
      TP_CHECKER = 3'd1,
      TP_RAMP    = 3'd2,
      TP_GRID    = 3'd3,
      TP_SCROLL  = 3'd4
   } tp_mode_e;

   localparam logic [2:0] GRB_WHITE   = 3'b111;
   localparam logic [2:0] GRB_YELLOW  = 3'b110;
   localparam logic [2:0] GRB_CYAN    = 3'b101;
   localparam logic [2:0] GRB_GREEN   = 3'b100;
   localparam logic [2:0] GRB_MAGENTA = 3'b011;
   localparam logic [2:0] GRB_RED     = 3'b010;
   localparam logic [2:0] GRB_BLUE    = 3'b001;
   localparam logic [2:0] GRB_BLACK   = 3'b000;

   function automatic logic [2:0] bar_grb(input logic [2:0] idx);
      logic [2:0] c;
      case (idx)
         3'd0:    c = GRB_WHITE;
         3'd1:    c = GRB_YELLOW;
         3'd2:    c = GRB_CYAN;
         3'd3:    c = GRB_GREEN;
         3'd4:    c = GRB_MAGENTA;
         3'd5:    c = GRB_RED;
         3'd6:    c = GRB_BLUE;
         default: c = GRB_BLACK;
      endcase
      return c;
   endfunction

   // Unused selector codes fall back to colour bars.
   function automatic tp_mode_e map_sel(input logic [2:0] sel);
      return (sel > 3'd4) ? TP_BARS : tp_mode_e'(sel);
   endfunction

   function automatic tp_mode_e next_mode(input tp_mode_e m);
      return (m == TP_SCROLL) ? TP_BARS : tp_mode_e'(m + 3'd1);
   endfunction

endpackage

// File: rtl/test_pattern_gen_bar_tracker.sv
// Divider-free bar tracker: counts pixels within a bar and steps the bar index,
// stopping after 8 bars past the base loaded at the start of the line.
module test_pattern_gen_bar_tracker #(
   parameter int HW        = 9,
   parameter int BAR_WIDTH = 44
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [HW-1:0] hc,
   input  logic [2:0]    base,
   output logic [2:0]    bar_idx,
   output logic          bar_vis
);
   localparam logic [HW-1:0] PX_LAST = HW'(BAR_WIDTH - 1);

   logic [HW-1:0] px_cnt_reg;
   logic [3:0]    bar_idx_reg;
   logic [2:0]    base_reg;
   logic [3:0]    slot;

   // Bars advanced since line start; reaching 8 means past the visible slots.
   assign slot    = bar_idx_reg - {1'b0, base_reg};
   assign bar_idx = bar_idx_reg[2:0];
   assign bar_vis = ~slot[3];

   always_ff @(posedge clk) begin
      if (rst) begin
         px_cnt_reg  <= '0;
         bar_idx_reg <= '0;
         base_reg    <= '0;
      end else if (hc == '0) begin
         base_reg <= base;
         if (BAR_WIDTH == 1) begin
            px_cnt_reg  <= '0;
            bar_idx_reg <= {1'b0, base} + 4'd1;
         end else begin
            px_cnt_reg  <= HW'(1);
            bar_idx_reg <= {1'b0, base};
         end
      end else if (px_cnt_reg == PX_LAST) begin
         px_cnt_reg <= '0;
         if (!slot[3])
            bar_idx_reg <= bar_idx_reg + 4'd1;
      end else begin
         px_cnt_reg <= px_cnt_reg + HW'(1);
      end
   end

endmodule

// File: rtl/test_pattern_gen.sv
// Parametrised video test-pattern source: five patterns, frame-synchronous mode
// switching with optional auto-cycling, registered RGB aligned with csync.
module test_pattern_gen #(
   parameter int CW          = 3,
   parameter int HW          = 9,
   parameter int BAR_WIDTH   = 44,
   parameter int CHECK_LOG2  = 4,
   parameter int GRID_LOG2   = 5,
   parameter int RAMP_SHIFT  = 5,
   parameter int AUTO_FRAMES = 100
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [HW-1:0] hc,
   input  logic [HW-1:0] vc,
   input  logic          blank,
   input  logic          csync_in,
   input  logic [2:0]    pattern_sel,
   input  logic          auto_en,
   output logic [CW-1:0] r,
   output logic [CW-1:0] g,
   output logic [CW-1:0] b,
   output logic          csync,
   output logic [2:0]    cur_pattern
);
   import test_pattern_gen_pkg::*;

   localparam int AW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
   localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_FRAMES - 1);

   tp_mode_e      mode_reg, mode_next;
   logic [7:0]    frame_cnt_reg, frame_cnt_next;
   logic [AW-1:0] auto_cnt_reg, auto_cnt_next;
   logic          frame_start, hc_zero;
   logic [2:0]    base, trk_idx, bar_sel;
   logic          trk_vis, bar_vis_eff;
   logic [2:0]    grb;
   logic [CW-1:0] pix_r, pix_g, pix_b;

   assign hc_zero     = (hc == '0);
   assign frame_start = hc_zero && (vc == '0);
   assign cur_pattern = mode_reg;

   always_comb begin
      mode_next      = mode_reg;
      frame_cnt_next = frame_cnt_reg;
      auto_cnt_next  = auto_cnt_reg;
      if (frame_start) begin
         frame_cnt_next = frame_cnt_reg + 8'd1;
         if (auto_en) begin
            if (auto_cnt_reg == AUTO_LAST) begin
               auto_cnt_next = '0;
               mode_next     = next_mode(mode_reg);
            end else begin
               auto_cnt_next = auto_cnt_reg + AW'(1);
            end
         end else begin
            auto_cnt_next = '0;
            mode_next     = map_sel(pattern_sel);
         end
      end
   end

   // The frame-start pixel already uses the new mode and frame count, so a
   // frame is never split between two patterns.
   assign base        = (mode_next == TP_SCROLL) ? frame_cnt_next[2:0] : 3'd0;
   assign bar_sel     = hc_zero ? base : trk_idx;
   assign bar_vis_eff = hc_zero | trk_vis;

   test_pattern_gen_bar_tracker #(
      .HW        (HW),
      .BAR_WIDTH (BAR_WIDTH)
   ) u_tracker (
      .clk     (clk),
      .rst     (rst),
      .hc      (hc),
      .base    (base),
      .bar_idx (trk_idx),
      .bar_vis (trk_vis)
   );

   always_comb begin
      grb = GRB_BLACK;
      case (mode_next)
         TP_BARS, TP_SCROLL: if (bar_vis_eff) grb = bar_grb(bar_sel);
         TP_CHECKER: if (hc[CHECK_LOG2] ^ vc[CHECK_LOG2]) grb = GRB_WHITE;
         TP_GRID: if (hc[GRID_LOG2-1:0] == '0 || vc[GRID_LOG2-1:0] == '0) grb = GRB_WHITE;
         default: grb = GRB_BLACK;
      endcase
      pix_g = {CW{grb[2]}};
      pix_r = {CW{grb[1]}};
      pix_b = {CW{grb[0]}};
      if (mode_next == TP_RAMP) begin
         pix_r = hc[RAMP_SHIFT +: CW];
         pix_g = hc[RAMP_SHIFT +: CW];
         pix_b = hc[RAMP_SHIFT +: CW];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r             <= '0;
         g             <= '0;
         b             <= '0;
         csync         <= 1'b1;
         mode_reg      <= TP_BARS;
         frame_cnt_reg <= '0;
         auto_cnt_reg  <= '0;
      end else begin
         r             <= blank ? '0 : pix_r;
         g             <= blank ? '0 : pix_g;
         b             <= blank ? '0 : pix_b;
         csync         <= csync_in;
         mode_reg      <= mode_next;
         frame_cnt_reg <= frame_cnt_next;
         auto_cnt_reg  <= auto_cnt_next;
      end
   end

endmodule
